cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM that sequences the 16-bit CPU datapath (decoder, regfile, ALU, PC, IR, memory port).
//  Walks each instruction through FETCH -> DECODE -> EXEC [-> MEM -> WBACK].
//  Raises the enables for each datapath register and the memory request/handshake.
//  Consumes the decoder's opcode/type/wb outputs and the PSR condition result.
// PARAMETERS
//  OP_LOAD      8'h40  opcode {instr[15:12],instr[7:4]} of LOAD
//  OP_STOR      8'h44  opcode of STOR
//  OP_JALR      8'h48  opcode of JALR
//  OP_JCOND     8'h4C  opcode of Jcond
//  ACK_TIMEOUT  16     max cycles waiting for mem_ack before FAULT (>=2)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset      in   1  synchronous, active-high
//  run        in   1  1 = may leave FETCH to start next instruction; 0 = hold in FETCH idle
//  opcode     in   8  decoder opcode, valid from DECODE onward (IR-stable)
//  itype      in   2  decoder type: 00 R, 01 I, 10 P (load/store), 11 J
//  wb         in   1  decoder writeback flag (R/I only; ignored for P/J)
//  cond_true  in   1  PSR condition for Jcond, sampled in EXEC
//  mem_ack    in   1  memory completed current request (read data valid / write done)
//  mem_req    out  1  memory request, held high until mem_ack
//  mem_we     out  1  1 = write (STOR), valid while mem_req
//  addr_sel   out  1  0 = PC drives address, 1 = Rsrc (muxB) drives address
//  ir_load    out  1  latch mem read data into IR
//  pc_inc     out  1  PC <= PC+1
//  pc_load    out  1  PC <= Rtarget (muxB)
//  reg_we     out  1  regfile write to en_reg
//  wb_sel     out  2  reg write source: 00 ALU, 01 mem data, 10 PC+1 (link)
//  flag_we    out  1  update PSR flags from ALU
//  fault      out  1  sticky; memory handshake timed out
//  state_o    out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: state=FETCH, all outputs 0, fault=0, timeout counter=0. Reset mid-handshake drops mem_req same edge.
//  States (3-bit): FETCH=0, DECODE=1, EXEC=2, MEM=3, WBACK=4, FAULT=7.
//  FETCH: if run: mem_req=1, mem_we=0, addr_sel=0. On mem_ack: ir_load=1, pc_inc=1 (same cycle) -> DECODE.
//    run=0 with no request outstanding: stay, mem_req=0. Once mem_req raised it stays until ack/timeout, run ignored.
//  DECODE: one cycle, no enables (decoder settles on new IR) -> EXEC.
//  EXEC by itype:
//    R/I: flag_we=1, reg_we=wb, wb_sel=00 -> FETCH. (CMP/CMPI/NOP: wb=0 so no write.)
//    P: -> MEM, no enables.
//    J, opcode==OP_JALR: reg_we=1, wb_sel=10, pc_load=1 -> FETCH (link captures PC+1 before load; PC already incremented).
//    J, opcode==OP_JCOND: pc_load=cond_true -> FETCH.
//    Any other J opcode: treated as NOP -> FETCH.
//  MEM: mem_req=1, addr_sel=1, mem_we=(opcode==OP_STOR). On mem_ack: LOAD -> WBACK, STOR -> FETCH.
//    Decoder wb is NOT used for P-type; load/store decided from opcode only.
//  WBACK: reg_we=1, wb_sel=01 (mem data registered by datapath on ack) -> FETCH.
//  Timeout: counter clears on entry to FETCH/MEM and on ack; increments each cycle mem_req=1 and mem_ack=0.
//    Reaching ACK_TIMEOUT-1 without ack -> FAULT. FAULT: fault=1, all enables 0, stays until reset.
//  mem_ack outside a request is ignored. mem_ack in first request cycle is accepted (min fetch = 1 cycle).
//  Latency (ack in 1 cycle): R/I/J = 3 cycles, STOR = 4, LOAD = 5.
//  All outputs are combinational decodes of state + inputs. Only state, counter and fault are registers.
//  Enables are single-cycle pulses. No two of pc_inc/pc_load assert in the same cycle.
// STRUCTURE
//  Shared package cpu_pkg: itype codes (R/I/P/J), opcode constants (LOAD/STOR/JALR/JCOND), wb_sel codes, state encoding.
//    Decoder and this FSM both import it.
//  Optional sub-module mem_hs_timer: timeout counter + expiry flag (width $clog2(ACK_TIMEOUT)).
//  Everything else is one always block for the state register and one for the output decode.
// TESTING
//  ADD (itype=00, wb=1), ack every cycle -> FETCH,DECODE,EXEC; exactly one ir_load, pc_inc, flag_we, reg_we (wb_sel=00).
//  CMPI (itype=01, wb=0) -> flag_we=1 in EXEC, reg_we never asserted.
//  LOAD (opcode 8'h40), data ack delayed 3 cycles -> mem_req/addr_sel=1 held 4 cycles in MEM, then WBACK reg_we with wb_sel=01.
//  STOR (8'h44) -> mem_we=1 only during MEM; no reg_we; back to FETCH.
//  Jcond: cond_true=0 -> no pc_load. cond_true=1 -> pc_load in EXEC.
//  JALR -> reg_we+wb_sel=10+pc_load in the same cycle.
//  Fault/reset: no mem_ack for ACK_TIMEOUT cycles in FETCH -> fault=1, state_o=7, enables 0.
//    Reset pulse -> state_o=0, fault=0 next edge.
//  Reset while in MEM with mem_req=1 -> mem_req=0 after the edge, no stray reg_we.
//  run=0 -> no mem_req. run=1 -> mem_req the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction type codes, control opcodes, writeback
// source select codes and the control FSM state encoding.
package cpu_pkg;

   typedef enum logic [1:0] {
      ITYPE_R = 2'b00,
      ITYPE_I = 2'b01,
      ITYPE_P = 2'b10,
      ITYPE_J = 2'b11
   } itype_e;

   localparam logic [7:0] OP_LOAD  = 8'h40;
   localparam logic [7:0] OP_STOR  = 8'h44;
   localparam logic [7:0] OP_JALR  = 8'h48;
   localparam logic [7:0] OP_JCOND = 8'h4C;

   localparam int ACK_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_LINK = 2'b10
   } wb_sel_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WBACK  = 3'd4,
      ST_FAULT  = 3'd7
   } state_e;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the CPU control FSM (master) and the datapath/memory side (slave).
interface cpu_ctrl_fsm_if;
   logic       run;
   logic [7:0] opcode;
   logic [1:0] itype;
   logic       wb;
   logic       cond_true;
   logic       mem_ack;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_load;
   logic       pc_inc;
   logic       pc_load;
   logic       reg_we;
   logic [1:0] wb_sel;
   logic       flag_we;
   logic       fault;
   logic [2:0] state_o;

   modport master (
      input  run, opcode, itype, wb, cond_true, mem_ack,
      output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
             reg_we, wb_sel, flag_we, fault, state_o
   );

   modport slave (
      output run, opcode, itype, wb, cond_true, mem_ack,
      input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
             reg_we, wb_sel, flag_we, fault, state_o
   );
endinterface

// File: rtl/mem_hs_timer.sv
// Memory handshake watchdog: counts unacknowledged request cycles and flags the
// last permitted cycle. Idle (no request) or an ack returns the count to zero.
module mem_hs_timer #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ack,
   output logic busy,
   output logic expired
);
   localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!req || ack)
         cnt_d = '0;
      else if (cnt_q != CNT_LAST)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // A nonzero count means a request is already outstanding.
   assign busy    = (cnt_q != '0);
   assign expired = (cnt_q == CNT_LAST);
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// state  | meaning
// FETCH  | request instruction word from PC, latch IR and bump PC on ack
// DECODE | decoder settles on new IR, no enables
// EXEC   | ALU/flag update, link+jump, conditional jump, or go to MEM
// MEM    | load/store handshake addressed by Rsrc
// WBACK  | write load data into regfile
// FAULT  | memory handshake timed out, everything idle until reset
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   cpu_ctrl_fsm_if.master  bus
);
   state_e  state_q, state_d;
   logic    fault_q, fault_d;
   logic    req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we, flag_we;
   wb_sel_e wb_sel;
   logic    tmr_busy, tmr_expired;

   mem_hs_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .ack     (bus.mem_ack),
      .busy    (tmr_busy),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fault_d  = fault_q;
      req      = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = WB_ALU;
      flag_we  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            // run only gates the start of a fetch; an outstanding one runs to ack/timeout
            if (bus.run || tmr_busy) begin
               req = 1'b1;
               if (bus.mem_ack) begin
                  ir_load = 1'b1;
                  pc_inc  = 1'b1;
                  state_d = ST_DECODE;
               end else if (tmr_expired) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (itype_e'(bus.itype))
               ITYPE_R, ITYPE_I: begin
                  flag_we = 1'b1;
                  reg_we  = bus.wb;
               end
               ITYPE_P: state_d = ST_MEM;
               ITYPE_J: begin
                  if (bus.opcode == OP_JALR) begin
                     reg_we  = 1'b1;
                     wb_sel  = WB_LINK;
                     pc_load = 1'b1;
                  end else if (bus.opcode == OP_JCOND) begin
                     pc_load = bus.cond_true;
                  end
               end
            endcase
         end
         ST_MEM: begin
            req      = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (bus.opcode == OP_STOR);
            if (bus.mem_ack) begin
               state_d = (bus.opcode == OP_LOAD) ? ST_WBACK : ST_FETCH;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
            end
         end
         ST_WBACK: begin
            reg_we  = 1'b1;
            wb_sel  = WB_MEM;
            state_d = ST_FETCH;
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FETCH;
      endcase
   end

   assign bus.mem_req  = req;
   assign bus.mem_we   = mem_we;
   assign bus.addr_sel = addr_sel;
   assign bus.ir_load  = ir_load;
   assign bus.pc_inc   = pc_inc;
   assign bus.pc_load  = pc_load;
   assign bus.reg_we   = reg_we;
   assign bus.wb_sel   = wb_sel;
   assign bus.flag_we  = flag_we;
   assign bus.fault    = fault_q;
   assign bus.state_o  = state_q;
endmodule
